// File: rtl/dsc_mul_sched_if.sv
// rtl/dsc_mul_sched_if.sv - request, response and multiplier bus of the dsc_mul scheduler
`timescale 1ns/1ps
interface dsc_mul_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int IN_W    = 6,
  parameter int CYC_W   = 26,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*4*IN_W-1:0] req_op;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      mul_rst;
  logic                      mul_en;
  logic [IN_W-1:0]           mul_a;
  logic [IN_W-1:0]           mul_b;
  logic [IN_W-1:0]           mul_c;
  logic [IN_W-1:0]           mul_d;
  logic [4*IN_W-1:0]         mul_z;
  logic                      mul_ov;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [4*IN_W-1:0]         resp_z;
  logic [CYC_W-1:0]          resp_cyc;
  logic                      resp_err;

  modport slave (
    input  req_valid, req_op, mul_z, mul_ov, resp_ready,
    output req_ready, mul_rst, mul_en, mul_a, mul_b, mul_c, mul_d,
           resp_valid, resp_id, resp_z, resp_cyc, resp_err
  );

  modport master (
    output req_valid, req_op, mul_z, mul_ov, resp_ready,
    input  req_ready, mul_rst, mul_en, mul_a, mul_b, mul_c, mul_d,
           resp_valid, resp_id, resp_z, resp_cyc, resp_err
  );
endinterface

// File: rtl/dsc_mul_sched.sv
// rtl/dsc_mul_sched.sv - round-robin scheduler sharing one dsc_mul among NUM_REQ requesters
`timescale 1ns/1ps
module dsc_mul_sched #(
  parameter int NUM_REQ    = 2,
  parameter int IN_W       = 6,
  parameter int CYC_W      = 26,
  parameter int MAX_CYCLES = 2**24 + 16,
  parameter int ID_W       = 1
) (
  input  logic             clk,
  input  logic             rst,
  dsc_mul_sched_if.slave   bus,
  output logic             busy
);
  localparam int OP_W = 4 * IN_W;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_hit;
  logic [OP_W-1:0]   op_sel;
  logic [CYC_W-1:0]  cyc;
  logic [CYC_W-1:0]  cyc_inc;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_hit && bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        grant_hit = 1'b1;
        grant_id  = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // ready is also held low while reset is asserted, since state alone reads IDLE then
  always_comb begin
    bus.req_ready = '0;
    if (rst && state == IDLE && grant_hit) bus.req_ready[grant_id] = 1'b1;
  end

  assign op_sel  = bus.req_op[int'(grant_id) * OP_W +: OP_W];
  assign cyc_inc = (cyc == '1) ? cyc : cyc + CYC_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      cyc            <= '0;
      busy           <= 1'b0;
      bus.mul_rst    <= 1'b1;
      bus.mul_en     <= 1'b0;
      bus.mul_a      <= '0;
      bus.mul_b      <= '0;
      bus.mul_c      <= '0;
      bus.mul_d      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_z     <= '0;
      bus.resp_cyc   <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_hit) begin
            {bus.mul_d, bus.mul_c, bus.mul_b, bus.mul_a} <= op_sel;
            bus.resp_id <= grant_id;
            rr_ptr      <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
            cyc         <= '0;
            busy        <= 1'b1;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          bus.mul_rst <= 1'b0;
          bus.mul_en  <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          cyc <= cyc_inc;
          // done takes priority over a timeout landing on the same cycle
          if (bus.mul_ov) begin
            bus.resp_z     <= bus.mul_z;
            bus.resp_cyc   <= cyc_inc;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.mul_rst    <= 1'b1;
            bus.mul_en     <= 1'b0;
            state          <= DONE;
          end else if (cyc_inc == CYC_W'(MAX_CYCLES)) begin
            bus.resp_z     <= '0;
            bus.resp_cyc   <= CYC_W'(MAX_CYCLES);
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= 1'b1;
            bus.mul_rst    <= 1'b1;
            bus.mul_en     <= 1'b0;
            state          <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsc_mul_sched.sv
// tb/tb_dsc_mul_sched.sv - directed self-checking bench for dsc_mul_sched with a stub multiplier
`timescale 1ns/1ps
module tb_dsc_mul_sched;
  localparam int NUM_REQ = 2;
  localparam int IN_W    = 6;
  localparam int CYC_W   = 26;
  localparam int MAXC    = 16;
  localparam int ID_W    = 1;
  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_EARLY  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  dsc_mul_sched_if #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .CYC_W(CYC_W), .ID_W(ID_W)) bus ();

  dsc_mul_sched #(
    .NUM_REQ(NUM_REQ), .IN_W(IN_W), .CYC_W(CYC_W), .MAX_CYCLES(MAXC), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int stub_mode = M_NORMAL;
  int stub_lat  = 5;
  int stub_cnt  = 0;

  // stub multiplier: ov on the stub_lat-th enabled cycle after a clear
  always @(posedge clk) begin
    if (bus.mul_rst) stub_cnt <= 0;
    else if (bus.mul_en) stub_cnt <= stub_cnt + 1;
  end
  assign bus.mul_ov = (stub_mode == M_EARLY) ||
                      (stub_mode == M_NORMAL && bus.mul_en && !bus.mul_rst && stub_cnt == stub_lat - 1);
  assign bus.mul_z  = (stub_mode == M_EARLY) ? 24'h05A5A5 :
                      24'(bus.mul_a) * 24'(bus.mul_b) * 24'(bus.mul_c) * 24'(bus.mul_d);

  function automatic logic [23:0] mk(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [23:0] op);
    bus.req_valid[k] = v;
    bus.req_op[k*24 +: 24] = op;
  endtask

  // called at a negedge with the DUT idle and requests already driven
  task automatic serve(input int exp_id, input logic [23:0] exp_op, input logic [23:0] exp_z,
                       input int exp_cyc, input logic exp_err, input int exp_lat, input int hold);
    int lat;
    #1;
    check("grant", 32'(bus.req_ready), 32'(1 << exp_id));
    @(negedge clk);
    lat = 1;
    bus.req_valid[exp_id] = 1'b0;
    bus.req_op[exp_id*24 +: 24] = ~exp_op;
    while (!bus.resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("operands", 32'({bus.mul_d, bus.mul_c, bus.mul_b, bus.mul_a}), 32'(exp_op));
    check("resp_id", 32'(bus.resp_id), 32'(exp_id));
    check("resp_z", 32'(bus.resp_z), 32'(exp_z));
    check("resp_cyc", 32'(bus.resp_cyc), 32'(exp_cyc));
    check("resp_err", 32'(bus.resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_z", 32'(bus.resp_z), 32'(exp_z));
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check("hold_en", 32'(bus.mul_en), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("resp_drop", 32'(bus.resp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    set_req(0, 1'b1, mk(15, 15, 15, 15));
    set_req(1, 1'b1, mk(2, 3, 4, 5));
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_mul_rst", 32'(bus.mul_rst), 32'd1);
    check("rst_mul_en", 32'(bus.mul_en), 32'd0);
    check("rst_operands", 32'({bus.mul_d, bus.mul_c, bus.mul_b, bus.mul_a}), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp", 32'({bus.resp_err, bus.resp_id, bus.resp_z}), 32'd0);
    check("rst_resp_cyc", 32'(bus.resp_cyc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;

    // both valid at reset exit: 0 then 1
    serve(0, mk(15, 15, 15, 15), 24'd50625, 5, 1'b0, 7, 0);
    serve(1, mk(2, 3, 4, 5), 24'd120, 5, 1'b0, 7, 0);
    // req0 alone moves the pointer to 1, then both valid: 1 then 0
    set_req(0, 1'b1, mk(63, 63, 63, 63));
    serve(0, mk(63, 63, 63, 63), 24'd15752961, 5, 1'b0, 7, 0);
    set_req(0, 1'b1, mk(1, 1, 1, 7));
    set_req(1, 1'b1, mk(10, 10, 10, 10));
    serve(1, mk(10, 10, 10, 10), 24'd10000, 5, 1'b0, 7, 0);
    serve(0, mk(1, 1, 1, 7), 24'd7, 5, 1'b0, 7, 0);

    // response back-pressure with another requester waiting
    stub_lat = 3;
    set_req(1, 1'b1, mk(3, 5, 7, 9));
    set_req(0, 1'b1, mk(4, 4, 4, 4));
    serve(1, mk(3, 5, 7, 9), 24'd945, 3, 1'b0, 5, 5);
    serve(0, mk(4, 4, 4, 4), 24'd256, 3, 1'b0, 5, 0);

    // timeout
    stub_mode = M_NEVER;
    set_req(1, 1'b1, mk(2, 2, 2, 2));
    serve(1, mk(2, 2, 2, 2), 24'd0, MAXC, 1'b1, MAXC + 2, 0);

    // reset three cycles into RUN
    stub_mode = M_NORMAL;
    stub_lat  = 8;
    set_req(0, 1'b1, mk(5, 5, 5, 5));
    #1;
    check("t5_grant", 32'(bus.req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("t5_running", 32'(bus.mul_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_mul_en", 32'(bus.mul_en), 32'd0);
    check("t5_mul_rst", 32'(bus.mul_rst), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_req_ready", 32'(bus.req_ready), 32'd0);
    check("t5_operands", 32'({bus.mul_d, bus.mul_c, bus.mul_b, bus.mul_a}), 32'd0);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    check("t5_no_resp", 32'(seen), 32'd0);
    set_req(0, 1'b1, mk(6, 6, 6, 6));
    serve(0, mk(6, 6, 6, 6), 24'd1296, 8, 1'b0, 10, 0);

    // ov during CLEAR is ignored
    stub_mode = M_EARLY;
    set_req(1, 1'b1, mk(1, 2, 3, 4));
    serve(1, mk(1, 2, 3, 4), 24'h05A5A5, 1, 1'b0, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
